// File: rtl/motion_pkg.sv
// Shared Q3.12 fixed-point definitions for the motion pipeline: word format,
// constants, quaternion type, rotation sequencer states and saturating negate.
package motion_pkg;

    localparam int W         = 16;
    localparam int FRAC_BITS = 12;

    localparam logic [W-1:0] Q_ONE = 16'h1000;
    localparam logic [W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [W-1:0] Q_MIN = 16'h8000;

    typedef struct packed {
        logic [W-1:0] w;
        logic [W-1:0] i;
        logic [W-1:0] j;
        logic [W-1:0] k;
    } quat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL1 = 2'd1,
        ST_MUL2 = 2'd2,
        ST_DONE = 2'd3
    } rot_state_e;

    // The most negative word has no positive twin, so it maps to MAX.
    function automatic logic [W-1:0] sat_neg(input logic [W-1:0] x);
        return (x == Q_MIN) ? Q_MAX : (~x + 1'b1);
    endfunction

endpackage

// File: rtl/mult_quat.sv
// Combinational Hamilton product p = a (x) b of two Q3.12 quaternions.
// Each component rounds half-up to the nearest LSB and saturates to the word range.
module mult_quat #(
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic signed [W-1:0] a_w,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] a_j,
    input  logic signed [W-1:0] a_k,
    input  logic signed [W-1:0] b_w,
    input  logic signed [W-1:0] b_i,
    input  logic signed [W-1:0] b_j,
    input  logic signed [W-1:0] b_k,
    output logic        [W-1:0] p_w,
    output logic        [W-1:0] p_i,
    output logic        [W-1:0] p_j,
    output logic        [W-1:0] p_k
);

    // Two guard bits cover the sum of four full-width products.
    localparam int PW = 2*W + 2;
    localparam logic signed [PW-1:0] HALF = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [PW-1:0] MAXV = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [PW-1:0] prod(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = PW'(x);
        ye = PW'(y);
        return xe * ye;
    endfunction

    function automatic logic [W-1:0] scale(input logic signed [PW-1:0] s);
        logic signed [PW-1:0] r;
        r = (s + HALF) >>> FRAC;
        if (r > MAXV)
            return MAXV[W-1:0];
        else if (r < MINV)
            return MINV[W-1:0];
        else
            return r[W-1:0];
    endfunction

    always_comb begin
        p_w = scale(prod(a_w, b_w) - prod(a_i, b_i) - prod(a_j, b_j) - prod(a_k, b_k));
        p_i = scale(prod(a_w, b_i) + prod(a_i, b_w) + prod(a_j, b_k) - prod(a_k, b_j));
        p_j = scale(prod(a_w, b_j) - prod(a_i, b_k) + prod(a_j, b_w) + prod(a_k, b_i));
        p_k = scale(prod(a_w, b_k) + prod(a_i, b_j) - prod(a_j, b_i) + prod(a_k, b_w));
    end

endmodule

// File: rtl/quat_rotate_ctrl.sv
// Rotates v by unit quaternion q as r = q (x) (0,v) (x) conj(q), reusing one
// combinational multiplier over two passes behind valid/ready handshakes.
module quat_rotate_ctrl
    import motion_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     q_w,
    input  logic [W-1:0]     q_i,
    input  logic [W-1:0]     q_j,
    input  logic [W-1:0]     q_k,
    input  logic [W-1:0]     v_x,
    input  logic [W-1:0]     v_y,
    input  logic [W-1:0]     v_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     r_w,
    output logic [W-1:0]     r_x,
    output logic [W-1:0]     r_y,
    output logic [W-1:0]     r_z,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    rot_state_e       state_q, state_d;
    quat_t            q_reg_q, q_reg_d;
    quat_t            v_reg_q, v_reg_d;
    quat_t            t_q, t_d;
    quat_t            r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;

    quat_t mul_a;
    quat_t mul_b;
    quat_t mul_p;
    logic  sel_conj;

    // IDLE and DONE leave the select at the first-pass setting.
    always_comb begin
        sel_conj = (state_q == ST_MUL2);
        if (sel_conj) begin
            mul_a = t_q;
            mul_b = '{w: q_reg_q.w, i: sat_neg(q_reg_q.i),
                      j: sat_neg(q_reg_q.j), k: sat_neg(q_reg_q.k)};
        end else begin
            mul_a = q_reg_q;
            mul_b = v_reg_q;
        end
    end

    mult_quat #(
        .W    (W),
        .FRAC (FRAC_BITS)
    ) u_mult (
        .a_w (mul_a.w), .a_i (mul_a.i), .a_j (mul_a.j), .a_k (mul_a.k),
        .b_w (mul_b.w), .b_i (mul_b.i), .b_j (mul_b.j), .b_k (mul_b.k),
        .p_w (mul_p.w), .p_i (mul_p.i), .p_j (mul_p.j), .p_k (mul_p.k)
    );

    assign in_ready = (state_q == ST_IDLE) && !rst;

    always_comb begin
        state_d     = state_q;
        q_reg_d     = q_reg_q;
        v_reg_d     = v_reg_q;
        t_d         = t_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    q_reg_d = '{w: q_w, i: q_i, j: q_j, k: q_k};
                    v_reg_d = '{w: '0, i: v_x, j: v_y, k: v_z};
                    state_d = ST_MUL1;
                end
            end
            ST_MUL1: begin
                t_d     = mul_p;
                state_d = ST_MUL2;
            end
            ST_MUL2: begin
                r_d         = mul_p;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    cnt_d       = cnt_q + 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_reg_q     <= '0;
            v_reg_q     <= '0;
            t_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_reg_q     <= q_reg_d;
            v_reg_q     <= v_reg_d;
            t_q         <= t_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign r_w       = r_q.w;
    assign r_x       = r_q.i;
    assign r_y       = r_q.j;
    assign r_z       = r_q.k;
    assign busy      = (state_q != ST_IDLE);
    assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_quat_rotate_ctrl.sv
// Directed self-checking bench for quat_rotate_ctrl with hand-computed expectations.
module tb_quat_rotate_ctrl;
    import motion_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] q_w, q_i, q_j, q_k;
    logic [15:0] v_x, v_y, v_z;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r_w, r_x, r_y, r_z;
    logic        busy;
    logic [7:0]  done_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    quat_rotate_ctrl #(.W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .q_w(q_w), .q_i(q_i), .q_j(q_j), .q_k(q_k),
        .v_x(v_x), .v_y(v_y), .v_z(v_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_w(r_w), .r_x(r_x), .r_y(r_y), .r_z(r_z),
        .busy(busy), .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic start_req(input logic [15:0] qw, qi, qj, qk, vx, vy, vz);
        for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
        q_w = qw; q_i = qi; q_j = qj; q_k = qk;
        v_x = vx; v_y = vy; v_z = vz;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic finish_hs();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b required 0 0 0", in_ready, out_valid, busy);
        end
        n_cmp++;
        if (done_cnt !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_cnt: done_cnt=%h required 00", done_cnt);
        end
        n_cmp++;
        if ({r_w, r_x, r_y, r_z} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_r: r=%h %h %h %h required 0 0 0 0", r_w, r_x, r_y, r_z);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
        $display("txn reset: in_ready=%b done_cnt=%h", in_ready, done_cnt);
    endtask

    task automatic test_identity();
        int waited;
        start_req(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0800, 16'h0400, 16'hFC00);
        wait_valid(waited);
        n_cmp++;
        if (waited + 1 !== 3) begin
            n_bad++;
            $display("FAIL identity_latency: got %0d cycles required 3", waited + 1);
        end
        n_cmp++;
        if ({r_w, r_x, r_y, r_z} !== {16'h0000, 16'h0800, 16'h0400, 16'hFC00}) begin
            n_bad++;
            $display("FAIL identity_r: r=%h %h %h %h required 0000 0800 0400 fc00", r_w, r_x, r_y, r_z);
        end
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL identity_busy: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        finish_hs();
        n_cmp++;
        if (done_cnt !== 8'h01 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL identity_cnt: done_cnt=%h out_valid=%b required 01 0", done_cnt, out_valid);
        end
        $display("txn identity: r=%h %h %h %h done_cnt=%h", r_w, r_x, r_y, r_z, done_cnt);
    endtask

    task automatic test_rot90();
        int waited;
        int dw, dx, dy, dz;
        start_req(16'h0B50, 16'h0, 16'h0, 16'h0B50, 16'h1000, 16'h0, 16'h0);
        wait_valid(waited);
        dw = int'($signed(r_w));
        dx = int'($signed(r_x));
        dy = int'($signed(r_y)) - 4096;
        dz = int'($signed(r_z));
        n_cmp++;
        if (!out_valid || dx > 4 || dx < -4) begin
            n_bad++;
            $display("FAIL rot90_x: r_x=%h required 0000+-4", r_x);
        end
        n_cmp++;
        if (dy > 4 || dy < -4) begin
            n_bad++;
            $display("FAIL rot90_y: r_y=%h required 1000+-4", r_y);
        end
        n_cmp++;
        if (dz > 4 || dz < -4 || dw > 4 || dw < -4) begin
            n_bad++;
            $display("FAIL rot90_zw: r_z=%h r_w=%h required 0000+-4", r_z, r_w);
        end
        finish_hs();
        n_cmp++;
        if (done_cnt !== 8'h02) begin
            n_bad++;
            $display("FAIL rot90_cnt: done_cnt=%h required 02", done_cnt);
        end
        $display("txn rot90: r=%h %h %h %h done_cnt=%h", r_w, r_x, r_y, r_z, done_cnt);
    endtask

    task automatic test_backpressure();
        int waited;
        int idle_bad;
        start_req(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0200, 16'hFD00);
        wait_valid(waited);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {r_w, r_x, r_y, r_z} !== {16'h0000, 16'h0100, 16'h0200, 16'hFD00}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b r=%h %h %h %h required 1 0 0000 0100 0200 fd00",
                         c, out_valid, in_ready, r_w, r_x, r_y, r_z);
            end
            in_valid = c[0] ? 1'b0 : 1'b1;
            q_w = 16'h0B50; q_k = 16'h0B50; v_x = 16'h1234;
            @(negedge clk);
        end
        in_valid = 1'b0;
        finish_hs();
        n_cmp++;
        if (done_cnt !== 8'h03 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: done_cnt=%h out_valid=%b required 03 0", done_cnt, out_valid);
        end
        idle_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 8'h03) idle_bad++;
        end
        n_cmp++;
        if (idle_bad !== 0) begin
            n_bad++;
            $display("FAIL bp_single_hs: %0d idle cycles showed activity required 0", idle_bad);
        end
        $display("txn backpressure: done_cnt=%h", done_cnt);
    endtask

    task automatic test_sat_conj();
        int waited;
        start_req(16'h1000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        n_cmp++;
        if (dut.mul_b.i !== 16'h7FFF || dut.mul_b.w !== 16'h1000) begin
            n_bad++;
            $display("FAIL sat_operand: b_w=%h b_i=%h required 1000 7fff", dut.mul_b.w, dut.mul_b.i);
        end
        wait_valid(waited);
        n_cmp++;
        if (out_valid !== 1'b1 || {r_w, r_x, r_y, r_z} !== 64'h0) begin
            n_bad++;
            $display("FAIL sat_r: out_valid=%b r=%h %h %h %h required 1 0 0 0 0", out_valid, r_w, r_x, r_y, r_z);
        end
        finish_hs();
        $display("txn sat_conj: done_cnt=%h", done_cnt);
    endtask

    task automatic test_reset_mid();
        int waited;
        int ghost;
        start_req(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0300, 16'h0500, 16'h0700);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (dut.state_q !== ST_IDLE || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_state: state=%0d out_valid=%b required 0 0", dut.state_q, out_valid);
        end
        n_cmp++;
        if (done_cnt !== 8'h00 || {r_w, r_x, r_y, r_z} !== 64'h0) begin
            n_bad++;
            $display("FAIL rstmid_clear: done_cnt=%h r=%h %h %h %h required 00 0 0 0 0", done_cnt, r_w, r_x, r_y, r_z);
        end
        rst = 1'b0;
        ghost = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ghost++;
        end
        n_cmp++;
        if (ghost !== 0) begin
            n_bad++;
            $display("FAIL rstmid_ghost: out_valid seen %0d cycles required 0", ghost);
        end
        start_req(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0011, 16'h0022, 16'hFFEE);
        wait_valid(waited);
        n_cmp++;
        if (waited + 1 !== 3 || {r_x, r_y, r_z} !== {16'h0011, 16'h0022, 16'hFFEE}) begin
            n_bad++;
            $display("FAIL rstmid_next: latency=%0d r=%h %h %h required 3 0011 0022 ffee", waited + 1, r_x, r_y, r_z);
        end
        finish_hs();
        n_cmp++;
        if (done_cnt !== 8'h01) begin
            n_bad++;
            $display("FAIL rstmid_cnt: done_cnt=%h required 01", done_cnt);
        end
        $display("txn reset_mid: done_cnt=%h", done_cnt);
    endtask

    task automatic test_back_to_back();
        int acc, hs, last, bad_sp, bad_r, cyc;
        logic [7:0] cnt_before, cnt_after;
        acc = 0; hs = 0; last = -1; bad_sp = 0; bad_r = 0; cyc = 0;
        cnt_before = 8'h55; cnt_after = 8'h55;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        q_w = 16'h1000; q_i = 16'h0; q_j = 16'h0; q_k = 16'h0;
        v_x = 16'h0123; v_y = 16'h0456; v_z = 16'hFEDC;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (cyc < 1200) begin
            if (in_valid && in_ready) begin
                acc++;
                if (last >= 0 && cyc - last != 4) bad_sp++;
                last = cyc;
            end
            if (out_valid && out_ready) begin
                hs++;
                if ({r_x, r_y, r_z} !== {16'h0123, 16'h0456, 16'hFEDC}) bad_r++;
                if (hs == 256) cnt_before = done_cnt;
                $display("txn stream %0d: r=%h %h %h done_cnt=%h", hs, r_x, r_y, r_z, done_cnt);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc == 256) in_valid = 1'b0;
            if (hs == 256) begin
                cnt_after = done_cnt;
                break;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (hs !== 256 || acc !== 256) begin
            n_bad++;
            $display("FAIL stream_count: handshakes=%0d accepts=%0d required 256 256", hs, acc);
        end
        n_cmp++;
        if (bad_sp !== 0) begin
            n_bad++;
            $display("FAIL stream_spacing: %0d accepts not 4 cycles apart required 0", bad_sp);
        end
        n_cmp++;
        if (bad_r !== 0) begin
            n_bad++;
            $display("FAIL stream_r: %0d wrong results required 0", bad_r);
        end
        n_cmp++;
        if (cnt_before !== 8'hFF || cnt_after !== 8'h00) begin
            n_bad++;
            $display("FAIL stream_wrap: done_cnt before=%h after=%h required ff 00", cnt_before, cnt_after);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        q_w = '0; q_i = '0; q_j = '0; q_k = '0;
        v_x = '0; v_y = '0; v_z = '0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_rot90();
        test_backpressure();
        test_sat_conj();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
